// File: rtl/proc_trace_pkg.sv
// Shared types for the processor commit-trace checker.
package proc_trace_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // One expected commit; dc marks the data field as don't-care.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        dc;
  } entry_t;

  // "No mismatch yet" index; users slice it down to their index width.
  localparam logic [31:0] ERR_NONE = '1;

endpackage

// File: rtl/proc_trace_fifo.sv
// Synchronous FIFO of expected trace entries. Pointers carry one extra MSB so
// full and empty are distinguishable; 'last' flags exactly one entry held.
module proc_trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic   last
);
  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW:0]    wr_q, rd_q;
  logic [AW:0]    cnt;

  assign cnt   = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign last  = (cnt == (AW+1)'(1));
  assign head  = mem[rd_q[AW-1:0]];

  // Pointer update; flush discards all held entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/proc_trace_checker.sv
// Commit-trace checker: compares each committed {addr,data} against a
// preloaded ordered list, reporting pass/fail, error count, first-mismatch
// index and hang timeout.
// Optional macro TRACE_CHECK_FIRST_ERR_EN adds first_err_addr/first_err_data,
// capturing the actual trace values of the first mismatch.
module proc_trace_checker
  import proc_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_val,
  output logic                     load_rdy,
  input  logic [31:0]              load_addr,
  input  logic [31:0]              load_data,
  input  logic                     load_dc,
  input  logic                     start,
  input  logic                     trace_val,
  input  logic [31:0]              trace_addr,
  input  logic [31:0]              trace_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   err_index
`ifdef TRACE_CHECK_FIRST_ERR_EN
  ,
  output logic [31:0]              first_err_addr,
  output logic [31:0]              first_err_data
`endif
);
  localparam int IW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_NONE = ERR_NONE[IW-1:0];

  state_e         state_q;
  logic [7:0]     err_cnt_q;
  logic [IW-1:0]  err_idx_q;
  logic [IW-1:0]  ord_q;
  logic [TW-1:0]  tmo_q;
  logic           pass_q, timeout_q;

  entry_t         head, din;
  logic           full, empty, last;
  logic           push, pop, flush, mismatch, tmo_hit;

  assign din      = '{addr: load_addr, data: load_data, dc: load_dc};
  assign push     = load_val && (state_q == IDLE) && !full;
  assign pop      = (state_q == RUN) && trace_val && !empty;
  assign mismatch = pop && ((head.addr != trace_addr) ||
                            (!head.dc && (head.data != trace_data)));
  assign tmo_hit  = (state_q == RUN) && !trace_val && (tmo_q == TW'(TIMEOUT - 1));
  assign flush    = tmo_hit;

  proc_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  // Outputs depend only on state registers, never directly on inputs.
  assign load_rdy  = (state_q == IDLE) && !full;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_cnt_q;
  assign err_index = err_idx_q;

  // Control FSM with comparator bookkeeping and hang detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      err_cnt_q <= '0;
      err_idx_q <= IDX_NONE;
      ord_q     <= '0;
      tmo_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ord_q <= '0;
            tmo_q <= '0;
            // A load on the same edge as start still joins the run.
            if (empty && !push) begin
              state_q <= DONE;
              pass_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (trace_val) begin
            tmo_q <= '0;
            ord_q <= ord_q + 1'b1;
            if (mismatch) begin
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              if (err_idx_q == IDX_NONE) err_idx_q <= ord_q;
            end
            if (last) begin
              state_q <= DONE;
              pass_q  <= (err_cnt_q == 8'd0) && !mismatch;
            end
          end else if (tmo_hit) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TRACE_CHECK_FIRST_ERR_EN
  logic [31:0] fe_addr_q, fe_data_q;

  // Capture the offending trace values on the first mismatch only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_addr_q <= '0;
      fe_data_q <= '0;
    end else if (mismatch && (err_idx_q == IDX_NONE)) begin
      fe_addr_q <= trace_addr;
      fe_data_q <= trace_data;
    end
  end

  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`endif

endmodule

// File: tb/tb_proc_trace_checker.sv
// Directed self-checking bench for proc_trace_checker (DEPTH=16, TIMEOUT=4).
module tb_proc_trace_checker;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_val = 1'b0, load_dc = 1'b0, start = 1'b0, trace_val = 1'b0;
  logic [31:0] load_addr = '0, load_data = '0, trace_addr = '0, trace_data = '0;
  logic        load_rdy, busy, done, pass, timeout;
  logic [7:0]  err_count;
  logic [4:0]  err_index;
`ifdef TRACE_CHECK_FIRST_ERR_EN
  logic [31:0] first_err_addr, first_err_data;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  proc_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .load_val(load_val), .load_rdy(load_rdy),
    .load_addr(load_addr), .load_data(load_data), .load_dc(load_dc),
    .start(start),
    .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .err_index(err_index)
`ifdef TRACE_CHECK_FIRST_ERR_EN
    , .first_err_addr(first_err_addr), .first_err_data(first_err_data)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_one(input logic [31:0] a, input logic [31:0] d, input logic dc);
    load_val = 1'b1; load_addr = a; load_data = d; load_dc = dc;
    step();
    load_val = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic trace_one(input logic [31:0] a, input logic [31:0] d);
    trace_val = 1'b1; trace_addr = a; trace_data = d;
    step();
    trace_val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (load_rdy !== 1'b1) begin fails++; $display("FAIL rst_load_rdy got=%b exp=1", load_rdy); end
    checks++; if ({busy, done, pass, timeout} !== 4'b0000) begin fails++; $display("FAIL rst_flags got=%b exp=0000", {busy, done, pass, timeout}); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    checks++; if (err_index !== 5'h1f) begin fails++; $display("FAIL rst_err_index got=%h exp=1f", err_index); end
  endtask

  task automatic test_pass();
    do_reset();
    load_one(32'h200, 32'h5, 1'b0);
    load_one(32'h204, 32'h7, 1'b0);
    do_start();
    checks++; if (busy !== 1'b1 || load_rdy !== 1'b0) begin fails++; $display("FAIL pass_run got busy=%b rdy=%b exp busy=1 rdy=0", busy, load_rdy); end
    trace_one(32'h200, 32'h5);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL pass_mid_busy got=%b exp=1", busy); end
    trace_one(32'h204, 32'h7);
    checks++; if ({done, pass, busy} !== 3'b110) begin fails++; $display("FAIL pass_done got done/pass/busy=%b exp=110", {done, pass, busy}); end
    checks++; if (err_count !== 8'd0 || err_index !== 5'h1f) begin fails++; $display("FAIL pass_errs got cnt=%0d idx=%h exp cnt=0 idx=1f", err_count, err_index); end
    // Commits after DONE are ignored.
    trace_one(32'h999, 32'h1);
    checks++; if ({done, pass} !== 2'b11 || err_count !== 8'd0) begin fails++; $display("FAIL pass_after_done got done/pass=%b cnt=%0d exp 11 cnt=0", {done, pass}, err_count); end
  endtask

  task automatic test_data_mismatch();
    do_reset();
    load_one(32'h300, 32'h1, 1'b0);
    load_one(32'h304, 32'h7, 1'b0);
    load_one(32'h308, 32'h9, 1'b0);
    do_start();
    trace_one(32'h300, 32'h1);
    trace_one(32'h304, 32'h8);
    trace_one(32'h308, 32'h9);
    checks++; if ({done, pass} !== 2'b10) begin fails++; $display("FAIL mm_done got done/pass=%b exp=10", {done, pass}); end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL mm_err_count got=%0d exp=1", err_count); end
    checks++; if (err_index !== 5'd1) begin fails++; $display("FAIL mm_err_index got=%0d exp=1", err_index); end
`ifdef TRACE_CHECK_FIRST_ERR_EN
    checks++; if (first_err_data !== 32'h8 || first_err_addr !== 32'h304) begin fails++; $display("FAIL mm_first_err got addr=%h data=%h exp 304/8", first_err_addr, first_err_data); end
`endif
  endtask

  task automatic test_dont_care();
    do_reset();
    load_one(32'h208, 32'h0, 1'b1);
    do_start();
    trace_one(32'h208, 32'hdead);
    checks++; if ({done, pass} !== 2'b11 || err_count !== 8'd0) begin fails++; $display("FAIL dc_data got done/pass=%b cnt=%0d exp 11 cnt=0", {done, pass}, err_count); end
    do_reset();
    load_one(32'h208, 32'h0, 1'b1);
    do_start();
    trace_one(32'h20c, 32'h0);
    checks++; if ({done, pass} !== 2'b10 || err_count !== 8'd1) begin fails++; $display("FAIL dc_addr got done/pass=%b cnt=%0d exp 10 cnt=1", {done, pass}, err_count); end
    checks++; if (err_index !== 5'd0) begin fails++; $display("FAIL dc_addr_index got=%0d exp=0", err_index); end
  endtask

  task automatic test_timeout();
    do_reset();
    load_one(32'h100, 32'h1, 1'b0);
    load_one(32'h104, 32'h2, 1'b0);
    do_start();
    trace_one(32'h100, 32'h1);
    repeat (TIMEOUT - 1) step();
    checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin fails++; $display("FAIL tmo_early got busy=%b tmo=%b exp busy=1 tmo=0", busy, timeout); end
    step();
    checks++; if ({done, timeout, pass} !== 3'b110) begin fails++; $display("FAIL tmo_hit got done/tmo/pass=%b exp=110", {done, timeout, pass}); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL tmo_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++; if (load_rdy !== 1'b1) begin fails++; $display("FAIL full_rdy_last got=%b exp=1", load_rdy); end
      end
      load_one(32'h1000 + 32'(i * 4), 32'(i), 1'b0);
    end
    checks++; if (load_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy got=%b exp=0", load_rdy); end
    load_one(32'hbad0, 32'hbad, 1'b0);
    do_start();
    for (int i = 0; i < DEPTH; i++) trace_one(32'h1000 + 32'(i * 4), 32'(i));
    checks++; if ({done, pass, err_count} !== {2'b11, 8'd0}) begin fails++; $display("FAIL full_run got done/pass=%b cnt=%0d exp 11 cnt=0", {done, pass}, err_count); end
    do_reset();
    do_start();
    checks++; if ({done, pass, busy} !== 3'b110) begin fails++; $display("FAIL empty_start got done/pass/busy=%b exp=110", {done, pass, busy}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_val = 1'b1; load_addr = 32'h400; load_data = 32'h44; load_dc = 1'b0; start = 1'b1;
    step();
    load_val = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_run got busy=%b exp=1", busy); end
    trace_one(32'h400, 32'h44);
    checks++; if ({done, pass} !== 2'b11) begin fails++; $display("FAIL b2b_done got done/pass=%b exp=11", {done, pass}); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_one(32'h500, 32'h1, 1'b0);
    load_one(32'h504, 32'h2, 1'b0);
    load_one(32'h508, 32'h3, 1'b0);
    do_start();
    trace_one(32'h500, 32'hff);
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL mr_pre_err got=%0d exp=1", err_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done} !== 2'b00 || load_rdy !== 1'b1) begin fails++; $display("FAIL mr_state got busy/done=%b rdy=%b exp 00 rdy=1", {busy, done}, load_rdy); end
    checks++; if (err_count !== 8'd0 || err_index !== 5'h1f) begin fails++; $display("FAIL mr_errs got cnt=%0d idx=%h exp cnt=0 idx=1f", err_count, err_index); end
    @(posedge clk); #1 rst = 1'b0;
    // Commits while idle change nothing.
    trace_one(32'h504, 32'h2);
    checks++; if ({busy, done, err_count} !== {2'b00, 8'd0}) begin fails++; $display("FAIL mr_idle_trace got busy/done=%b cnt=%0d exp 00 cnt=0", {busy, done}, err_count); end
    // FIFO must be flushed: start finishes at once.
    do_start();
    checks++; if ({done, pass} !== 2'b11) begin fails++; $display("FAIL mr_flushed got done/pass=%b exp=11", {done, pass}); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_data_mismatch();
    test_dont_care();
    test_timeout();
    test_full();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
